// File: rtl/jt12_pg_sched_if.sv
// Link between the slot sequencer and the shared phase-generator comb block.
// The sequencer is the master; the comb block is the slave.
interface jt12_pg_sched_if;
    logic [19:0]       pg_phase_in;
    logic              pg_rst;
    logic signed [5:0] pg_detune;
    logic [16:0]       pg_phinc;
    logic [4:0]        pg_keycode_in;
    logic signed [5:0] pg_detune_in;
    logic [16:0]       pg_phinc_in;
    logic [19:0]       pg_phase_out;
    logic [9:0]        pg_phase_op;

    modport master (
        output pg_phase_in, pg_rst, pg_detune, pg_phinc,
        input  pg_keycode_in, pg_detune_in, pg_phinc_in, pg_phase_out, pg_phase_op
    );

    modport slave (
        input  pg_phase_in, pg_rst, pg_detune, pg_phinc,
        output pg_keycode_in, pg_detune_in, pg_phinc_in, pg_phase_out, pg_phase_op
    );
endinterface

// File: rtl/jt12_pg_sched.sv
// Phase-generator slot sequencer: walks 24 operator slots, owns the phase
// memory and pending key-on resets, and runs the two-stage comb pipeline.
module jt12_pg_sched (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clk_en,
    input  logic            i_keyon_we,
    input  logic [2:0]      i_keyon_ch,
    input  logic [3:0]      i_keyon_op,
    output logic [2:0]      o_s1_ch,
    output logic [1:0]      o_s1_op,
    output logic            o_zero,
    output logic [4:0]      o_keycode,
    output logic [9:0]      o_phase_op,
    output logic [2:0]      o_op_ch,
    output logic [1:0]      o_op_op,
    output logic            o_op_valid,
    jt12_pg_sched_if.master pg
);
    localparam int SLOTS = 24;
    localparam int PH_W  = 20;
    localparam int INC_W = 17;

    logic [2:0]        r_ch_p1;
    logic [1:0]        r_op_p1;
    logic [2:0]        r_ch_p2;
    logic [1:0]        r_op_p2;
    logic              r_vld_p2;
    logic signed [5:0] r_detune_p2;
    logic [INC_W-1:0]  r_phinc_p2;
    logic [4:0]        r_keycode_p2;
    logic [9:0]        r_phase_op_p3;
    logic [2:0]        r_ch_p3;
    logic [1:0]        r_op_p3;
    logic              r_vld_p3;
    logic [PH_W-1:0]   r_mem [SLOTS];
    logic [SLOTS-1:0]  r_pend;
    logic [4:0]        w_s2_idx;
    logic [SLOTS-1:0]  w_set;
    logic [SLOTS-1:0]  w_clr;

    function automatic logic [4:0] slot_idx(input logic [1:0] op, input logic [2:0] ch);
        return 5'(op) * 5'd6 + 5'(ch);
    endfunction

    assign w_s2_idx = slot_idx(r_op_p2, r_ch_p2);

    always_comb begin
        w_set = '0;
        if (i_keyon_we && (i_keyon_ch < 3'd6)) begin
            for (int i = 0; i < 4; i++) begin
                if (i_keyon_op[i]) w_set[slot_idx(2'(i), i_keyon_ch)] = 1'b1;
            end
        end
    end

    assign w_clr = (i_clk_en && r_vld_p2) ? (24'd1 << w_s2_idx) : '0;

    // A set arriving with the stage-2 clear wins, so the reset lands on the next visit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pend <= '0;
        else        r_pend <= (r_pend & ~w_clr) | w_set;
    end

    // Stage 1: slot counter addressing the register file and comb block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_p1 <= '0;
            r_op_p1 <= '0;
        end else if (i_clk_en) begin
            if (r_ch_p1 == 3'd5) begin
                r_ch_p1 <= '0;
                r_op_p1 <= r_op_p1 + 2'd1;
            end else begin
                r_ch_p1 <= r_ch_p1 + 3'd1;
            end
        end
    end

    // Stage 2: registered comb stage-1 results, tagged with the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_p2      <= '0;
            r_op_p2      <= '0;
            r_vld_p2     <= 1'b0;
            r_detune_p2  <= '0;
            r_phinc_p2   <= '0;
            r_keycode_p2 <= '0;
        end else if (i_clk_en) begin
            r_ch_p2      <= r_ch_p1;
            r_op_p2      <= r_op_p1;
            r_vld_p2     <= 1'b1;
            r_detune_p2  <= pg.pg_detune_in;
            r_phinc_p2   <= pg.pg_phinc_in;
            r_keycode_p2 <= pg.pg_keycode_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) r_mem[i] <= '0;
        end else if (i_clk_en && r_vld_p2) begin
            r_mem[w_s2_idx] <= pg.pg_phase_out;
        end
    end

    // Stage 3: operator phase presented with its slot tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_op_p3 <= '0;
            r_ch_p3       <= '0;
            r_op_p3       <= '0;
            r_vld_p3      <= 1'b0;
        end else if (i_clk_en && r_vld_p2) begin
            r_phase_op_p3 <= pg.pg_phase_op;
            r_ch_p3       <= r_ch_p2;
            r_op_p3       <= r_op_p2;
            r_vld_p3      <= 1'b1;
        end
    end

    assign o_s1_ch        = r_ch_p1;
    assign o_s1_op        = r_op_p1;
    assign o_zero         = (r_ch_p1 == 3'd0) && (r_op_p1 == 2'd0);
    assign o_keycode      = r_keycode_p2;
    assign o_phase_op     = r_phase_op_p3;
    assign o_op_ch        = r_ch_p3;
    assign o_op_op        = r_op_p3;
    assign o_op_valid     = r_vld_p3;
    assign pg.pg_phase_in = r_mem[w_s2_idx];
    assign pg.pg_rst      = r_vld_p2 & r_pend[w_s2_idx];
    assign pg.pg_detune   = r_detune_p2;
    assign pg.pg_phinc    = r_phinc_p2;
endmodule

// File: tb/tb_jt12_pg_sched.sv
// Bench for jt12_pg_sched: a stub comb block adds the registered phinc to the
// stored phase, a hand-computed vector table plus a slot-level reference model.
module tb_jt12_pg_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_clk_en = 1'b0;
    logic       i_keyon_we = 1'b0;
    logic [2:0] i_keyon_ch = '0;
    logic [3:0] i_keyon_op = '0;
    logic [2:0] o_s1_ch;
    logic [1:0] o_s1_op;
    logic       o_zero;
    logic [4:0] o_keycode;
    logic [9:0] o_phase_op;
    logic [2:0] o_op_ch;
    logic [1:0] o_op_op;
    logic       o_op_valid;

    jt12_pg_sched_if pg_bus ();

    jt12_pg_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clk_en   (i_clk_en),
        .i_keyon_we (i_keyon_we),
        .i_keyon_ch (i_keyon_ch),
        .i_keyon_op (i_keyon_op),
        .o_s1_ch    (o_s1_ch),
        .o_s1_op    (o_s1_op),
        .o_zero     (o_zero),
        .o_keycode  (o_keycode),
        .o_phase_op (o_phase_op),
        .o_op_ch    (o_op_ch),
        .o_op_op    (o_op_op),
        .o_op_valid (o_op_valid),
        .pg         (pg_bus)
    );

    always #5 clk = ~clk;

    // Comb-block stub: keycode/detune identify the s1 slot, phase adds phinc
    logic [5:0]  tb_s1_idx;
    logic [19:0] tb_phase_out;
    assign tb_s1_idx             = 6'(o_s1_op) * 6'd6 + 6'(o_s1_ch);
    assign pg_bus.pg_keycode_in  = {o_s1_op, o_s1_ch};
    assign pg_bus.pg_detune_in   = $signed(6'd0 - tb_s1_idx);
    assign pg_bus.pg_phinc_in    = 17'h00100;
    assign tb_phase_out          = pg_bus.pg_rst ? 20'd0 : pg_bus.pg_phase_in + {3'd0, pg_bus.pg_phinc};
    assign pg_bus.pg_phase_out   = tb_phase_out;
    assign pg_bus.pg_phase_op    = tb_phase_out[19:10];

    int checks = 0;
    int failures = 0;
    int e = 0;
    logic [19:0] ref_mem [24];
    logic [23:0] ref_pend = '0;
    logic [9:0]  ref_ph = '0;
    int          ref_tag = 0;
    logic        ref_valid = 1'b0;

    typedef struct {
        int          e;
        logic [2:0]  s1_ch;
        logic [1:0]  s1_op;
        logic        zero;
        logic        valid;
        logic [2:0]  op_ch;
        logic [1:0]  op_op;
        logic [9:0]  ph;
        logic [4:0]  kc;
        logic [5:0]  dt;
        logic [19:0] pin;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic do_edge(input logic en, input logic kon, input logic [2:0] kch, input logic [3:0] kop);
        int s2;
        logic [19:0] out;
        i_clk_en   = en;
        i_keyon_we = kon;
        i_keyon_ch = kch;
        i_keyon_op = kop;
        @(posedge clk);
        #1;
        i_keyon_we = 1'b0;
        if (en) begin
            if (e >= 1) begin
                s2 = (e - 1) % 24;
                out = ref_pend[s2] ? 20'd0 : ref_mem[s2] + 20'h00100;
                ref_mem[s2]  = out;
                ref_pend[s2] = 1'b0;
                ref_ph       = out[19:10];
                ref_tag      = s2;
                ref_valid    = 1'b1;
            end
            e++;
        end
        if (kon && (kch < 3'd6)) begin
            for (int i = 0; i < 4; i++) if (kop[i]) ref_pend[i * 6 + int'(kch)] = 1'b1;
        end
    endtask

    task automatic check_state(input string t);
        int s1;
        int s2;
        s1 = e % 24;
        s2 = (e == 0) ? 0 : (e - 1) % 24;
        check({t, " s1_ch"},    32'(o_s1_ch), s1 % 6);
        check({t, " s1_op"},    32'(o_s1_op), s1 / 6);
        check({t, " zero"},     32'(o_zero), (s1 == 0) ? 1 : 0);
        check({t, " pg_rst"},   32'(pg_bus.pg_rst), (e >= 1) ? 32'(ref_pend[s2]) : 0);
        check({t, " phase_in"}, 32'(pg_bus.pg_phase_in), 32'(ref_mem[s2]));
        check({t, " valid"},    32'(o_op_valid), 32'(ref_valid));
        check({t, " op_ch"},    32'(o_op_ch), ref_tag % 6);
        check({t, " op_op"},    32'(o_op_op), ref_tag / 6);
        check({t, " phase_op"}, 32'(o_phase_op), 32'(ref_ph));
    endtask

    task automatic advance_to_s2(input int slot, input string t);
        for (int k = 0; k < 24 && !(e >= 1 && ((e - 1) % 24) == slot); k++) begin
            do_edge(1'b1, 1'b0, 3'd0, 4'd0);
            check_state(t);
        end
    endtask

    initial begin
        int nrst;
        for (int i = 0; i < 24; i++) ref_mem[i] = '0;
        //              e   s1ch  s1op  zero  vld   opch  opop  ph      kc      dt     pin
        vecs[0]  = '{0,  3'd0, 2'd0, 1'b1, 1'b0, 3'd0, 2'd0, 10'd0, 5'd0,  6'h00, 20'h000};
        vecs[1]  = '{1,  3'd1, 2'd0, 1'b0, 1'b0, 3'd0, 2'd0, 10'd0, 5'd0,  6'h00, 20'h000};
        vecs[2]  = '{2,  3'd2, 2'd0, 1'b0, 1'b1, 3'd0, 2'd0, 10'd0, 5'd1,  6'h3F, 20'h000};
        vecs[3]  = '{3,  3'd3, 2'd0, 1'b0, 1'b1, 3'd1, 2'd0, 10'd0, 5'd2,  6'h3E, 20'h000};
        vecs[4]  = '{7,  3'd1, 2'd1, 1'b0, 1'b1, 3'd5, 2'd0, 10'd0, 5'd8,  6'h3A, 20'h000};
        vecs[5]  = '{24, 3'd0, 2'd0, 1'b1, 1'b1, 3'd4, 2'd3, 10'd0, 5'd29, 6'h29, 20'h000};
        vecs[6]  = '{25, 3'd1, 2'd0, 1'b0, 1'b1, 3'd5, 2'd3, 10'd0, 5'd0,  6'h00, 20'h100};
        vecs[7]  = '{26, 3'd2, 2'd0, 1'b0, 1'b1, 3'd0, 2'd0, 10'd0, 5'd1,  6'h3F, 20'h100};
        vecs[8]  = '{48, 3'd0, 2'd0, 1'b1, 1'b1, 3'd4, 2'd3, 10'd0, 5'd29, 6'h29, 20'h100};
        vecs[9]  = '{73, 3'd1, 2'd0, 1'b0, 1'b1, 3'd5, 2'd3, 10'd0, 5'd0,  6'h00, 20'h300};
        vecs[10] = '{74, 3'd2, 2'd0, 1'b0, 1'b1, 3'd0, 2'd0, 10'd1, 5'd1,  6'h3F, 20'h300};
        vecs[11] = '{97, 3'd1, 2'd0, 1'b0, 1'b1, 3'd5, 2'd3, 10'd1, 5'd0,  6'h00, 20'h400};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            while (e < vecs[i].e) do_edge(1'b1, 1'b0, 3'd0, 4'd0);
            check($sformatf("v%0d s1_ch", i),    32'(o_s1_ch),    32'(vecs[i].s1_ch));
            check($sformatf("v%0d s1_op", i),    32'(o_s1_op),    32'(vecs[i].s1_op));
            check($sformatf("v%0d zero", i),     32'(o_zero),     32'(vecs[i].zero));
            check($sformatf("v%0d valid", i),    32'(o_op_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d op_ch", i),    32'(o_op_ch),    32'(vecs[i].op_ch));
            check($sformatf("v%0d op_op", i),    32'(o_op_op),    32'(vecs[i].op_op));
            check($sformatf("v%0d phase_op", i), 32'(o_phase_op), 32'(vecs[i].ph));
            check($sformatf("v%0d keycode", i),  32'(o_keycode),  32'(vecs[i].kc));
            check($sformatf("v%0d detune", i),   {26'd0, pg_bus.pg_detune}, 32'(vecs[i].dt));
            check($sformatf("v%0d phinc", i),    32'(pg_bus.pg_phinc), (vecs[i].e >= 1) ? 32'h100 : 32'h0);
            check($sformatf("v%0d phase_in", i), 32'(pg_bus.pg_phase_in), 32'(vecs[i].pin));
        end

        // Key-on ch2 ops 0 and 2 -> slots 2 and 14 reset exactly once
        do_edge(1'b1, 1'b1, 3'd2, 4'b0101);
        check_state("kon");
        nrst = 0;
        for (int k = 0; k < 24; k++) begin
            do_edge(1'b1, 1'b0, 3'd0, 4'd0);
            check_state("kon_w1");
            if (pg_bus.pg_rst) nrst++;
        end
        check("kon rst_count_frame1", 32'(nrst), 32'd2);
        nrst = 0;
        for (int k = 0; k < 24; k++) begin
            do_edge(1'b1, 1'b0, 3'd0, 4'd0);
            check_state("kon_w2");
            if (pg_bus.pg_rst) nrst++;
            if (((e - 1) % 24) == 2) check("kon slot2 restarted", 32'(pg_bus.pg_phase_in), 32'h0);
            if (((e - 1) % 24) == 3) check("kon slot3 untouched", 32'(pg_bus.pg_phase_in), 32'h500);
        end
        check("kon rst_count_frame2", 32'(nrst), 32'd0);

        // Key-on for slot 7 coinciding with its stage-2 clear keeps the flag set
        advance_to_s2(20, "cf_adv");
        do_edge(1'b1, 1'b1, 3'd1, 4'b0010);
        check_state("cf_set");
        advance_to_s2(7, "cf_adv");
        check("cf pre pg_rst", 32'(pg_bus.pg_rst), 32'd1);
        do_edge(1'b1, 1'b1, 3'd1, 4'b0010);
        check_state("cf_hit");
        advance_to_s2(7, "cf_adv");
        check("cf reapplied pg_rst", 32'(pg_bus.pg_rst), 32'd1);
        do_edge(1'b1, 1'b0, 3'd0, 4'd0);
        check("cf reset phase_op", 32'(o_phase_op), 32'd0);
        advance_to_s2(7, "cf_adv");
        check("cf cleared pg_rst", 32'(pg_bus.pg_rst), 32'd0);

        // clk_en at one-in-three; key-on while disabled is still captured
        for (int k = 0; k < 30; k++) begin
            do_edge(1'b1, 1'b0, 3'd0, 4'd0);
            check_state("ce_on");
            do_edge(1'b0, 1'b0, 3'd0, 4'd0);
            check_state("ce_off");
            if (k == 5) do_edge(1'b0, 1'b1, 3'd4, 4'b1000);
            else        do_edge(1'b0, 1'b0, 3'd0, 4'd0);
            check_state("ce_off2");
        end

        // Asynchronous reset mid-frame with s1 at slot 13
        for (int k = 0; k < 24 && (e % 24) != 13; k++) do_edge(1'b1, 1'b0, 3'd0, 4'd0);
        check("rst pre s1 slot13", 32'(tb_s1_idx), 32'd13);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst s1_ch",    32'(o_s1_ch), 0);
        check("rst s1_op",    32'(o_s1_op), 0);
        check("rst zero",     32'(o_zero), 1);
        check("rst phase_op", 32'(o_phase_op), 0);
        check("rst op_ch",    32'(o_op_ch), 0);
        check("rst op_op",    32'(o_op_op), 0);
        check("rst valid",    32'(o_op_valid), 0);
        check("rst keycode",  32'(o_keycode), 0);
        check("rst detune",   {26'd0, pg_bus.pg_detune}, 0);
        check("rst phinc",    32'(pg_bus.pg_phinc), 0);
        check("rst pg_rst",   32'(pg_bus.pg_rst), 0);
        check("rst phase_in", 32'(pg_bus.pg_phase_in), 0);
        e = 0;
        for (int i = 0; i < 24; i++) ref_mem[i] = '0;
        ref_pend  = '0;
        ref_ph    = '0;
        ref_tag   = 0;
        ref_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_state("rst_rel");
        for (int k = 0; k < 30; k++) begin
            do_edge(1'b1, 1'b0, 3'd0, 4'd0);
            check_state("rst_run");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jt12_pg_sched.md
# jt12_pg_sched

Slot sequencer for the time-multiplexed phase generator: it walks the 24 operator slots (6 channels × 4 operators), owns the 24-entry phase accumulator memory, and drives the shared phase-generator combinational block through a two-stage pipeline. It turns key-on events into per-slot pending phase resets and presents the resulting 10-bit operator phase to the operator stage together with its slot tag.

## Interface
- No parameters: slot count fixed at 24, phase width 20, phinc width 17.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  advance enable; all state frozen when low
- keyon_we  in  1  key-on strobe (one cycle, independent of clk_en)
- keyon_ch  in  3  channel 0–5 for strobe; 6–7 ignored
- keyon_op  in  4  operator mask for strobe, bit i = operator i
- s1_ch, s1_op  out  3, 2  slot whose block/fnum/pms/detune the register file must present this cycle
- zero  out  1  high while s1 slot is ch0/op0
- pg_phase_in  out  20  stage-2 phase to comb block
- pg_rst  out  1  stage-2 reset request to comb block
- pg_detune  out  6 signed  stage-1 detune_out, registered
- pg_phinc  out  17  stage-1 phinc_out, registered
- pg_keycode_in  in  5  comb keycode (stage 1)
- pg_detune_in  in  6 signed  comb detune_out (stage 1)
- pg_phinc_in  in  17  comb phinc_out (stage 1)
- pg_phase_out  in  20  comb phase_out (stage 2)
- pg_phase_op  in  10  comb phase_op (stage 2)
- keycode  out  5  stage-1 keycode, registered, for envelope generator
- phase_op  out  10  registered operator phase
- op_ch, op_op  out  3, 2  slot tag of phase_op
- op_valid  out  1  high from first completed slot after reset onward

## Operation
- Slot counter: ch increments 0→5 on each clk_en; at 5→0, op increments 0→3 and wraps. Slot index s = op·6 + ch.
- Stage 1 (slot s1): comb computes keycode/detune/phinc from the register file’s values for s1. On clk_en, the block registers pg_detune, pg_phinc and keycode, and tags them with s2 := s1.
- Stage 2 (slot s2): pg_phase_in = mem[s2], pg_rst = pend[s2]. On clk_en, the block writes mem[s2] ← pg_phase_out, captures phase_op ← pg_phase_op, sets op_ch/op_op ← s2, clears pend[s2] and sets op_valid.
- Pending reset: 24 flags. keyon_we sets pend[keyon_ch·… slot op·6+ch] for each set bit of keyon_op. keyon_ch > 5 is a no-op.
- Same-cycle conflict: a set of pend[k] coinciding with its clear in stage 2 resolves to set, so the reset is applied on the next visit.
- No read/write hazard: each slot is visited once per 24 clk_en, and the write-back completes before the next read of that slot.
- Arithmetic is entirely in the comb block; this block only stores and routes values, and performs no truncation or extension.

## Timing
- Reset (async, rst_n=0): ch=0, op=0, zero=1, all mem=0, all pend=0, pipeline registers 0, phase_op=0, op_ch=op_op=0, op_valid=0, keycode=0, pg_rst=0.
- Latency: slot presented on s1 at clk_en edge N → phase_op for that slot visible after edge N+2 (two clk_en).
- zero high for exactly 1 of every 24 clk_en periods.
- clk_en low: counters, mem, pipeline and outputs hold; keyon_we still sets flags.
- Reset released mid-frame restarts at slot 0 with empty pipeline; first op_valid after 2 clk_en.
- mem updates only in stage 2 under clk_en; no other write path.

## Test plan
- Reset, then 48 clk_en with comb model → zero pulses at cycles 0 and 24; s1 sequence ch0..5 op0, ch0..5 op1, … ; op_valid rises after 2nd edge.
- Constant stub pg_phinc path: comb model phase_out = phase_in + 0x100 → after 3 full frames, mem[s] = 0x300 for all s; phase_op = 0x000 then 0x001 progression matching phase_out[19:10].
- keyon_we ch=2, op mask 0b0101 at frame 5 → pg_rst=1 only when s2 ∈ {2, 14}; those slots’ phase restarts from 0; all others unaffected; flags clear after one visit.
- keyon for slot 7 asserted in the same cycle slot 7 is in stage 2 with pend set → pend stays 1; reset applied again on next frame.
- clk_en toggled 1-of-3 → identical phase_op/op_ch sequence to the full-rate run, just stretched; keyon during clk_en=0 still captured.
- rst_n pulsed low mid-frame at slot 13 → all outputs 0 immediately (asynchronous); resumes at slot 0 and mem restarts at 0.
